// File: rtl/boton_eventos_if.sv
// Button-event bus: debounced level in, registered level and event pulses out.
// The slave modport is the classifier side; master is the upstream/consumer side.
interface boton_eventos_if;
    logic boton_debounce_i;
    logic presionado_o;
    logic pulso_flanco_o;
    logic pulso_corto_o;
    logic pulso_largo_o;
    logic pulso_doble_o;

    modport slave (
        input  boton_debounce_i,
        output presionado_o,
        output pulso_flanco_o,
        output pulso_corto_o,
        output pulso_largo_o,
        output pulso_doble_o
    );

    modport master (
        output boton_debounce_i,
        input  presionado_o,
        input  pulso_flanco_o,
        input  pulso_corto_o,
        input  pulso_largo_o,
        input  pulso_doble_o
    );
endinterface

// File: rtl/boton_eventos.sv
// Press-event classifier: press edge, short, long and double press pulses from a debounced button.
// Optional macro BOTON_AUTO_REPETIR_EN makes the long-press pulse auto-repeat while held.
module boton_eventos #(
    parameter int unsigned ACTIVO_BAJO    = 1,
    parameter int unsigned CICLOS_LARGO   = 50_000_000,
    parameter int unsigned CICLOS_DOBLE   = 25_000_000,
    parameter int unsigned CICLOS_REPETIR = 10_000_000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    boton_eventos_if.slave  bus
);

    localparam int unsigned MAX_LD     = (CICLOS_LARGO > CICLOS_DOBLE) ? CICLOS_LARGO : CICLOS_DOBLE;
    localparam int unsigned MAX_CICLOS = (MAX_LD > CICLOS_REPETIR) ? MAX_LD : CICLOS_REPETIR;
    localparam int          CW         = $clog2(MAX_CICLOS) + 1;

    localparam logic [CW-1:0] LARGO_FIN = CW'(CICLOS_LARGO - 1);
    localparam logic [CW-1:0] DOBLE_FIN = CW'(CICLOS_DOBLE - 1);
`ifdef BOTON_AUTO_REPETIR_EN
    localparam logic [CW-1:0] REPETIR_FIN = CW'(CICLOS_REPETIR - 1);
`endif
    localparam logic L_INVERTIR = (ACTIVO_BAJO != 0);

    typedef enum logic [2:0] {
        REPOSO,
        PRESIONADO,
        LARGO,
        ESPERA,
        SEGUNDO
    } estado_t;

    estado_t        r_estado, w_estado_nxt;
    logic [CW-1:0]  r_cuenta, w_cuenta_nxt, w_cuenta_inc;
    logic           r_p_q;
    logic           w_p, w_press, w_release;
    logic           w_corto_nxt, w_largo_nxt, w_doble_nxt;
    logic           r_presionado, r_flanco, r_corto, r_largo, r_doble;

    assign w_p          = bus.boton_debounce_i ^ L_INVERTIR;
    assign w_press      = w_p & ~r_p_q;
    assign w_release    = ~w_p & r_p_q;
    assign w_cuenta_inc = (r_cuenta == '1) ? r_cuenta : r_cuenta + 1'b1;

    // p_q resets to "pressed" so a button held through reset needs a fresh press.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_estado <= REPOSO;
            r_cuenta <= '0;
            r_p_q    <= 1'b1;
        end else begin
            r_estado <= w_estado_nxt;
            r_cuenta <= w_cuenta_nxt;
            r_p_q    <= w_p;
        end
    end

    // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latch).
    always_comb begin
        w_estado_nxt = r_estado;
        w_cuenta_nxt = r_cuenta;
        case (r_estado)
            REPOSO: begin
                if (w_press) begin
                    w_estado_nxt = PRESIONADO;
                    w_cuenta_nxt = '0;
                end
            end
            PRESIONADO: begin
                if (w_release) begin
                    w_estado_nxt = ESPERA;
                    w_cuenta_nxt = '0;
                end else if (r_cuenta == LARGO_FIN) begin
                    w_estado_nxt = LARGO;
                    w_cuenta_nxt = '0;
                end else begin
                    w_cuenta_nxt = w_cuenta_inc;
                end
            end
            LARGO: begin
                if (w_release) begin
                    w_estado_nxt = REPOSO;
                    w_cuenta_nxt = '0;
                end
`ifdef BOTON_AUTO_REPETIR_EN
                else if (r_cuenta == REPETIR_FIN) begin
                    w_cuenta_nxt = '0;
                end else begin
                    w_cuenta_nxt = w_cuenta_inc;
                end
`endif
            end
            ESPERA: begin
                // A press on the timeout edge still counts as a double.
                if (w_press) begin
                    w_estado_nxt = SEGUNDO;
                    w_cuenta_nxt = '0;
                end else if (r_cuenta == DOBLE_FIN) begin
                    w_estado_nxt = REPOSO;
                    w_cuenta_nxt = '0;
                end else begin
                    w_cuenta_nxt = w_cuenta_inc;
                end
            end
            SEGUNDO: begin
                if (w_release) begin
                    w_estado_nxt = REPOSO;
                    w_cuenta_nxt = '0;
                end
            end
            default: begin
                w_estado_nxt = REPOSO;
                w_cuenta_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_corto_nxt = 1'b0;
        w_largo_nxt = 1'b0;
        w_doble_nxt = 1'b0;
        case (r_estado)
            PRESIONADO: w_largo_nxt = ~w_release & (r_cuenta == LARGO_FIN);
`ifdef BOTON_AUTO_REPETIR_EN
            LARGO:      w_largo_nxt = ~w_release & (r_cuenta == REPETIR_FIN);
`endif
            ESPERA: begin
                w_doble_nxt = w_press;
                w_corto_nxt = ~w_press & (r_cuenta == DOBLE_FIN);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_presionado <= 1'b0;
            r_flanco     <= 1'b0;
            r_corto      <= 1'b0;
            r_largo      <= 1'b0;
            r_doble      <= 1'b0;
        end else begin
            r_presionado <= w_p;
            r_flanco     <= w_press;
            r_corto      <= w_corto_nxt;
            r_largo      <= w_largo_nxt;
            r_doble      <= w_doble_nxt;
        end
    end

    assign bus.presionado_o   = r_presionado;
    assign bus.pulso_flanco_o = r_flanco;
    assign bus.pulso_corto_o  = r_corto;
    assign bus.pulso_largo_o  = r_largo;
    assign bus.pulso_doble_o  = r_doble;

endmodule

// File: tb/tb_boton_eventos.sv
// Directed bench for boton_eventos: short, long, double, window boundaries and reset cases.
// Pulse times are logged as the clock edge number whose sampled inputs caused them.
module tb_boton_eventos;
    localparam int LARGO   = 8;
    localparam int DOBLE   = 6;
    localparam int REPETIR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    int q_flanco[$];
    int q_corto[$];
    int q_largo[$];
    int q_doble[$];

    boton_eventos_if bus ();

    boton_eventos #(
        .ACTIVO_BAJO   (1),
        .CICLOS_LARGO  (LARGO),
        .CICLOS_DOBLE  (DOBLE),
        .CICLOS_REPETIR(REPETIR)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.pulso_flanco_o) q_flanco.push_back(cyc);
        if (bus.pulso_corto_o)  q_corto.push_back(cyc);
        if (bus.pulso_largo_o)  q_largo.push_back(cyc);
        if (bus.pulso_doble_o)  q_doble.push_back(cyc);
    end

    // Called on a falling edge; the level is first sampled at edge cyc+1.
    task automatic hold(input logic v, input int n);
        bus.boton_debounce_i = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.boton_debounce_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.presionado_o, bus.pulso_flanco_o, bus.pulso_corto_o, bus.pulso_largo_o, bus.pulso_doble_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000", {bus.presionado_o, bus.pulso_flanco_o,
                     bus.pulso_corto_o, bus.pulso_largo_o, bus.pulso_doble_o});
        end
        rst = 1'b0;
        hold(1'b1, 4);
        checks++;
        if (q_flanco.size() + q_corto.size() + q_largo.size() + q_doble.size() != 0 || bus.presionado_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: pulses=%0d presionado=%b expected 0 0",
                     q_flanco.size() + q_corto.size() + q_largo.size() + q_doble.size(), bus.presionado_o);
        end
    endtask

    task automatic test_short();
        int bf, bc, bl, bd, t_p, t_r;
        bf = q_flanco.size(); bc = q_corto.size(); bl = q_largo.size(); bd = q_doble.size();
        t_p = cyc + 1;
        hold(1'b0, 3);
        checks++;
        if (bus.presionado_o !== 1'b1) begin
            errors++;
            $display("FAIL short_presionado: got %b expected 1", bus.presionado_o);
        end
        t_r = cyc + 1;
        hold(1'b1, 12);
        checks++;
        if (bus.presionado_o !== 1'b0) begin
            errors++;
            $display("FAIL short_released: got %b expected 0", bus.presionado_o);
        end
        checks++;
        if (q_flanco.size() != bf + 1 || q_flanco[bf] != t_p) begin
            errors++;
            $display("FAIL short_flanco: count=%0d expected 1 at edge %0d", q_flanco.size() - bf, t_p);
        end
        checks++;
        if (q_corto.size() != bc + 1 || q_corto[bc] != t_r + DOBLE) begin
            errors++;
            $display("FAIL short_corto: count=%0d expected 1 at edge %0d", q_corto.size() - bc, t_r + DOBLE);
        end
        checks++;
        if (q_largo.size() != bl || q_doble.size() != bd) begin
            errors++;
            $display("FAIL short_others: largo=%0d doble=%0d expected 0 0", q_largo.size() - bl, q_doble.size() - bd);
        end
    endtask

    task automatic test_long();
        int bf, bc, bl, bd, t_p, n_exp;
        bf = q_flanco.size(); bc = q_corto.size(); bl = q_largo.size(); bd = q_doble.size();
        t_p = cyc + 1;
        hold(1'b0, 20);
        hold(1'b1, 12);
`ifdef BOTON_AUTO_REPETIR_EN
        n_exp = 3;
`else
        n_exp = 1;
`endif
        checks++;
        if (q_largo.size() != bl + n_exp) begin
            errors++;
            $display("FAIL long_count: got %0d expected %0d", q_largo.size() - bl, n_exp);
        end
        for (int i = 0; i < n_exp; i++) begin
            checks++;
            if (q_largo.size() <= bl + i || q_largo[bl + i] != t_p + LARGO + i * REPETIR) begin
                errors++;
                $display("FAIL long_time[%0d]: got %0d expected edge %0d", i,
                         (q_largo.size() > bl + i) ? q_largo[bl + i] : -1, t_p + LARGO + i * REPETIR);
            end
        end
        checks++;
        if (q_flanco.size() != bf + 1 || q_corto.size() != bc || q_doble.size() != bd) begin
            errors++;
            $display("FAIL long_others: flanco=%0d corto=%0d doble=%0d expected 1 0 0",
                     q_flanco.size() - bf, q_corto.size() - bc, q_doble.size() - bd);
        end
    endtask

    // Second press lands gap edges after the release edge.
    task automatic test_double(input string name, input int gap);
        int bf, bc, bl, bd, t_p1, t_r, t_p2;
        bf = q_flanco.size(); bc = q_corto.size(); bl = q_largo.size(); bd = q_doble.size();
        t_p1 = cyc + 1;
        hold(1'b0, 2);
        t_r = cyc + 1;
        hold(1'b1, gap);
        t_p2 = cyc + 1;
        hold(1'b0, 2);
        hold(1'b1, 12);
        checks++;
        if (q_doble.size() != bd + 1 || q_doble[bd] != t_p2) begin
            errors++;
            $display("FAIL %s_doble: count=%0d expected 1 at edge %0d", name, q_doble.size() - bd, t_p2);
        end
        checks++;
        if (q_corto.size() != bc || q_largo.size() != bl) begin
            errors++;
            $display("FAIL %s_others: corto=%0d largo=%0d expected 0 0", name, q_corto.size() - bc, q_largo.size() - bl);
        end
        checks++;
        if (q_flanco.size() != bf + 2 || q_flanco[bf] != t_p1 || q_flanco[bf + 1] != t_p2) begin
            errors++;
            $display("FAIL %s_flanco: count=%0d expected 2 at edges %0d %0d", name, q_flanco.size() - bf, t_p1, t_p2);
        end
    endtask

    task automatic test_late_second();
        int bc, bd, t_r, t_r2;
        bc = q_corto.size(); bd = q_doble.size();
        hold(1'b0, 2);
        t_r = cyc + 1;
        hold(1'b1, DOBLE + 1);
        hold(1'b0, 2);
        t_r2 = cyc + 1;
        hold(1'b1, 12);
        checks++;
        if (q_corto.size() != bc + 2 || q_corto[bc] != t_r + DOBLE || q_corto[bc + 1] != t_r2 + DOBLE) begin
            errors++;
            $display("FAIL late_corto: count=%0d expected 2 at edges %0d %0d", q_corto.size() - bc, t_r + DOBLE, t_r2 + DOBLE);
        end
        checks++;
        if (q_doble.size() != bd) begin
            errors++;
            $display("FAIL late_doble: got %0d expected 0", q_doble.size() - bd);
        end
    endtask

    task automatic test_reset_held();
        int bf, bc, bl, bd, t_p, t_r;
        bf = q_flanco.size(); bc = q_corto.size(); bl = q_largo.size(); bd = q_doble.size();
        bus.boton_debounce_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.presionado_o !== 1'b0) begin
            errors++;
            $display("FAIL held_in_reset_presionado: got %b expected 0", bus.presionado_o);
        end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (bus.presionado_o !== 1'b1) begin
            errors++;
            $display("FAIL held_presionado: got %b expected 1", bus.presionado_o);
        end
        hold(1'b1, 12);
        checks++;
        if (q_flanco.size() != bf || q_corto.size() != bc || q_largo.size() != bl || q_doble.size() != bd) begin
            errors++;
            $display("FAIL held_no_events: flanco=%0d corto=%0d largo=%0d doble=%0d expected all 0",
                     q_flanco.size() - bf, q_corto.size() - bc, q_largo.size() - bl, q_doble.size() - bd);
        end
        t_p = cyc + 1;
        hold(1'b0, 2);
        t_r = cyc + 1;
        hold(1'b1, 12);
        checks++;
        if (q_flanco.size() != bf + 1 || q_flanco[bf] != t_p || q_corto.size() != bc + 1 || q_corto[bc] != t_r + DOBLE) begin
            errors++;
            $display("FAIL held_then_short: flanco=%0d corto=%0d expected 1 at %0d and 1 at %0d",
                     q_flanco.size() - bf, q_corto.size() - bc, t_p, t_r + DOBLE);
        end
    endtask

    task automatic test_reset_espera();
        int bc, bl, bd, t_r, t_r2;
        bc = q_corto.size(); bl = q_largo.size(); bd = q_doble.size();
        hold(1'b0, 2);
        t_r = cyc + 1;
        hold(1'b1, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (q_corto.size() != bc || q_largo.size() != bl || q_doble.size() != bd) begin
            errors++;
            $display("FAIL espera_reset_dropped: corto=%0d largo=%0d doble=%0d expected 0 0 0 (release edge %0d)",
                     q_corto.size() - bc, q_largo.size() - bl, q_doble.size() - bd, t_r);
        end
        hold(1'b0, 2);
        t_r2 = cyc + 1;
        hold(1'b1, 12);
        checks++;
        if (q_corto.size() != bc + 1 || q_corto[bc] != t_r2 + DOBLE || q_doble.size() != bd) begin
            errors++;
            $display("FAIL espera_reset_reposo: corto=%0d doble=%0d expected 1 at edge %0d and 0",
                     q_corto.size() - bc, q_doble.size() - bd, t_r2 + DOBLE);
        end
    endtask

    initial begin
        bus.boton_debounce_i = 1'b1;
        @(negedge clk);
        test_reset();
        test_short();
        test_long();
        test_double("double", 3);
        test_double("double_edge", DOBLE);
        test_late_second();
        test_reset_held();
        test_reset_espera();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
